// File: rtl/piano_tone_gen.sv
`default_nettype none
// ============================================================================
// piano_tone_gen : turns the divided time base into ticks, debounces an 8-key
//                  keyboard on those ticks and plays the key as a square wave.
// Revision       : 1.0
// ============================================================================
module piano_tone_gen #(
   parameter int DEBOUNCE = 4,
   parameter int CNT_W    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_clk,
   input  logic [7:0] key,
   output logic       piezo,
   output logic [2:0] note_idx,
   output logic       note_valid
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_PLAY     = 2'd2
   } state_t;

   localparam logic [4:0] c_DB_LIM = 5'(DEBOUNCE);

   state_t           r_state, w_state_nxt;
   logic             r_tick_d;
   logic [7:0]       r_key_m, r_key_s;
   logic [2:0]       r_cand, w_cand_nxt;
   logic [2:0]       r_note_idx, w_note_idx_nxt;
   logic [3:0]       r_db_cnt, w_db_cnt_nxt;
   logic [CNT_W-1:0] r_tone_cnt, w_tone_cnt_nxt, w_hp_m1;
   logic             r_piezo, w_piezo_nxt;
   logic             w_tick, w_enc_valid;
   logic [2:0]       w_enc;
   logic [4:0]       w_db_inc;

   // tick_d resets high so a tick_clk already high at reset release is ignored
   assign w_tick      = tick_clk & ~r_tick_d;
   assign w_enc_valid = |r_key_s;

   always_comb begin
      w_enc = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (r_key_s[i]) w_enc = 3'(i);
      end
   end

   // Half-period minus one, in ticks, for C4..C5
   always_comb begin
      w_hp_m1 = CNT_W'(1910);
      case (r_note_idx)
         3'd0: w_hp_m1 = CNT_W'(1910);
         3'd1: w_hp_m1 = CNT_W'(1702);
         3'd2: w_hp_m1 = CNT_W'(1516);
         3'd3: w_hp_m1 = CNT_W'(1431);
         3'd4: w_hp_m1 = CNT_W'(1275);
         3'd5: w_hp_m1 = CNT_W'(1135);
         3'd6: w_hp_m1 = CNT_W'(1011);
         3'd7: w_hp_m1 = CNT_W'(955);
         default: w_hp_m1 = CNT_W'(1910);
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cand_nxt     = r_cand;
      w_db_cnt_nxt   = r_db_cnt;
      w_note_idx_nxt = r_note_idx;
      w_tone_cnt_nxt = r_tone_cnt;
      w_piezo_nxt    = r_piezo;
      w_db_inc       = {1'b0, r_db_cnt} + 5'd1;
      if (w_tick) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_enc_valid) begin
                  w_cand_nxt   = w_enc;
                  w_db_cnt_nxt = 4'd1;
                  if (c_DB_LIM == 5'd1) begin
                     w_state_nxt    = S_PLAY;
                     w_note_idx_nxt = w_enc;
                     w_tone_cnt_nxt = '0;
                     w_piezo_nxt    = 1'b0;
                  end else begin
                     w_state_nxt = S_DEBOUNCE;
                  end
               end
            end
            S_DEBOUNCE: begin
               if (!w_enc_valid) begin
                  w_state_nxt = S_IDLE;
               end else if (w_enc != r_cand) begin
                  w_cand_nxt   = w_enc;
                  w_db_cnt_nxt = 4'd1;
               end else if (w_db_inc == c_DB_LIM) begin
                  w_state_nxt    = S_PLAY;
                  w_note_idx_nxt = r_cand;
                  w_tone_cnt_nxt = '0;
                  w_piezo_nxt    = 1'b0;
               end else begin
                  w_db_cnt_nxt = w_db_inc[3:0];
               end
            end
            S_PLAY: begin
               // Release and key change win over a toggle on the same tick
               if (!w_enc_valid) begin
                  w_state_nxt = S_IDLE;
                  w_piezo_nxt = 1'b0;
               end else if (w_enc != r_note_idx) begin
                  w_state_nxt  = S_DEBOUNCE;
                  w_cand_nxt   = w_enc;
                  w_db_cnt_nxt = 4'd1;
                  w_piezo_nxt  = 1'b0;
               end else if (r_tone_cnt == w_hp_m1) begin
                  w_tone_cnt_nxt = '0;
                  w_piezo_nxt    = ~r_piezo;
               end else begin
                  w_tone_cnt_nxt = r_tone_cnt + 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_piezo_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_d   <= 1'b1;
         r_key_m    <= '0;
         r_key_s    <= '0;
         r_state    <= S_IDLE;
         r_cand     <= '0;
         r_db_cnt   <= '0;
         r_note_idx <= '0;
         r_tone_cnt <= '0;
         r_piezo    <= 1'b0;
      end else begin
         r_tick_d   <= tick_clk;
         r_key_m    <= key;
         r_key_s    <= r_key_m;
         r_state    <= w_state_nxt;
         r_cand     <= w_cand_nxt;
         r_db_cnt   <= w_db_cnt_nxt;
         r_note_idx <= w_note_idx_nxt;
         r_tone_cnt <= w_tone_cnt_nxt;
         r_piezo    <= w_piezo_nxt;
      end
   end

   assign piezo      = r_piezo;
   assign note_idx   = r_note_idx;
   assign note_valid = (r_state == S_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_piano_tone_gen.sv
`default_nettype none
// ============================================================================
// tb_piano_tone_gen : run-length reference model of the tone generator with
//                     directed timing scenarios and randomized key traffic.
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_piano_tone_gen;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_clk;
   logic [7:0] key;
   logic       piezo;
   logic [2:0] note_idx;
   logic       note_valid;

   int checks = 0;
   int errors = 0;
   int div_half = 5;
   bit gen_on = 1'b0;
   int tick_cnt = 0;

   // Model: a note plays once the same key code has been seen on DB
   // consecutive ticks; piezo is the parity of (ticks into the note / HP).
   int         m_run = 0;
   int         m_last = -1;
   logic [2:0] m_idx = 3'd0;
   logic       m_tick_d = 1'b1;
   logic [7:0] m_s1 = 8'h00;
   logic [7:0] m_s2 = 8'h00;
   logic       exp_valid;
   logic       exp_piezo;

   always #5 clk = ~clk;

   piano_tone_gen #(.DEBOUNCE(DB), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_clk   (tick_clk),
      .key        (key),
      .piezo      (piezo),
      .note_idx   (note_idx),
      .note_valid (note_valid)
   );

   function automatic int hp(input logic [2:0] i);
      case (i)
         3'd0: return 1911;
         3'd1: return 1703;
         3'd2: return 1517;
         3'd3: return 1432;
         3'd4: return 1276;
         3'd5: return 1136;
         3'd6: return 1012;
         default: return 956;
      endcase
   endfunction

   function automatic int enc8(input logic [7:0] k);
      int e = -1;
      for (int i = 7; i >= 0; i--) if (k[i]) e = i;
      return e;
   endfunction

   function automatic int run_after(input int run, input int last, input int e);
      if (e < 0) return 0;
      if (run > 0 && e == last) return run + 1;
      return 1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_tick_d <= 1'b1;
         m_s1     <= 8'h00;
         m_s2     <= 8'h00;
         m_run    <= 0;
         m_last   <= -1;
         m_idx    <= 3'd0;
      end else begin
         m_tick_d <= tick_clk;
         m_s1     <= key;
         m_s2     <= m_s1;
         if (tick_clk && !m_tick_d) begin
            tick_cnt <= tick_cnt + 1;
            m_run    <= run_after(m_run, m_last, enc8(m_s2));
            m_last   <= enc8(m_s2);
            if (run_after(m_run, m_last, enc8(m_s2)) >= DB) m_idx <= 3'(enc8(m_s2));
         end
      end
   end

   assign exp_valid = (m_run >= DB);
   assign exp_piezo = exp_valid && ((((m_run - DB) / hp(m_idx)) % 2) == 1);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_note_valid", 32'(note_valid), 32'(exp_valid));
      check("model_note_idx",   32'(note_idx),   32'(m_idx));
      check("model_piezo",      32'(piezo),      32'(exp_piezo));
   end

   // Divider stand-in: square wave with a half-period of div_half clocks
   initial begin
      tick_clk = 1'b1;
      wait (gen_on);
      forever begin
         repeat (div_half) @(negedge clk);
         tick_clk = ~tick_clk;
      end
   end

   task automatic wait_ticks(input int n);
      int start;
      int c;
      start = tick_cnt;
      c = 0;
      while (tick_cnt < start + n && c < n * 25 + 10) begin
         @(negedge clk);
         c++;
      end
      check("ticks_elapsed", 32'(tick_cnt - start), 32'(n));
   endtask

   task automatic wait_piezo(input logic v, input int lim, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (piezo !== v && n < lim);
      if (piezo !== v) n = -1;
   endtask

   initial begin
      int n;
      int hold;
      key = 8'h04;

      repeat (6) @(negedge clk);
      check("reset_piezo", 32'(piezo), 32'd0);
      check("reset_note_valid", 32'(note_valid), 32'd0);
      check("reset_note_idx", 32'(note_idx), 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      check("no_tick_while_high", 32'(note_valid), 32'd0);
      gen_on = 1'b1;

      // Single key, /10
      wait_ticks(3);
      check("single_after_3_ticks", 32'(note_valid), 32'd0);
      wait_ticks(1);
      check("single_after_4_ticks", 32'(note_valid), 32'd1);
      check("single_note_idx", 32'(note_idx), 32'd2);
      wait_piezo(1'b1, 16000, n);
      check("e4_first_rise_clk", 32'(n), 32'd15170);
      wait_piezo(1'b0, 16000, n);
      check("e4_half_period_clk", 32'(n), 32'd15170);

      // Release
      wait_ticks(1);
      key = 8'h00;
      wait_ticks(1);
      check("release_note_valid", 32'(note_valid), 32'd0);
      check("release_piezo", 32'(piezo), 32'd0);

      // Bounce
      key = 8'h04;
      wait_ticks(2);
      key = 8'h00;
      wait_ticks(1);
      key = 8'h04;
      check("bounce_gap_valid", 32'(note_valid), 32'd0);
      wait_ticks(3);
      check("bounce_after_3", 32'(note_valid), 32'd0);
      wait_ticks(1);
      check("bounce_after_4", 32'(note_valid), 32'd1);

      // Rate switch while playing C5
      key = 8'h80;
      wait_ticks(4);
      check("c5_note_valid", 32'(note_valid), 32'd1);
      check("c5_note_idx", 32'(note_idx), 32'd7);
      wait_piezo(1'b1, 10000, n);
      check("c5_first_rise_div10", 32'(n), 32'd9560);
      wait_piezo(1'b0, 10000, n);
      check("c5_half_period_div10", 32'(n), 32'd9560);
      div_half = 2;
      wait_piezo(1'b1, 10000, n);
      wait_piezo(1'b0, 5000, n);
      check("c5_half_period_div4", 32'(n), 32'd3824);
      check("c5_valid_after_switch", 32'(note_valid), 32'd1);

      // Asynchronous reset mid-play
      wait_piezo(1'b1, 5000, n);
      check("piezo_high_before_reset", 32'(piezo), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_piezo", 32'(piezo), 32'd0);
      check("async_rst_valid", 32'(note_valid), 32'd0);
      check("async_rst_idx", 32'(note_idx), 32'd0);
      key = 8'h00;
      repeat (4) @(negedge clk);
      rst = 1'b0;

      // Priority and key change, /4
      wait_ticks(2);
      key = 8'h22;
      wait_ticks(3);
      check("prio_after_3", 32'(note_valid), 32'd0);
      wait_ticks(1);
      check("prio_valid", 32'(note_valid), 32'd1);
      check("prio_idx", 32'(note_idx), 32'd1);
      wait_piezo(1'b1, 7000, n);
      check("d4_first_rise_div4", 32'(n), 32'd6812);
      key = 8'h20;
      wait_ticks(1);
      check("change_valid_cleared", 32'(note_valid), 32'd0);
      check("change_piezo_cleared", 32'(piezo), 32'd0);
      wait_ticks(2);
      check("change_after_3", 32'(note_valid), 32'd0);
      wait_ticks(1);
      check("change_valid", 32'(note_valid), 32'd1);
      check("change_idx", 32'(note_idx), 32'd5);
      wait_piezo(1'b1, 5000, n);
      check("a4_first_rise_div4", 32'(n), 32'd4544);

      // Randomized key traffic, checked by the model every cycle
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 3))
            0: key = 8'h00;
            1: key = 8'(1 << $urandom_range(0, 7));
            default: key = 8'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) div_half = (div_half == 2) ? 5 : 2;
         hold = $urandom_range(1, 40);
         repeat (hold) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/piano_tone_gen.md
# piano_tone_gen

Keyboard-to-tone stage of the FPGA piano, directly downstream of the selectable /10 ÷ /4 clock divider. It treats the divider's output square wave as a time base, edge-detecting it into one-cycle ticks in the system clock domain. On each tick it samples and debounces an 8-key keyboard and picks the highest-priority pressed key. It then drives a piezo square wave whose half-period, counted in ticks, comes from a fixed C4–C5 table.

## Interface
Parameters:
- DEBOUNCE, 4: consecutive ticks a key code must be stable before it plays (legal range 1–15).
- CNT_W, 16: width of the tone half-period counter (must be ≥ 11).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick_clk  in  1  divided clock from the upstream divider. It is a registered signal in the clk domain and is used as data, never as a clock.
- key  in  8  raw push-button levels (1 = pressed), asynchronous.
- piezo  out  1  tone square wave.
- note_idx  out  3  index of the key currently playing.
- note_valid  out  1  1 while a debounced note is playing.

## Operation
- Tick generation:
  - tick_d is a register copy of tick_clk.
  - tick = tick_clk & ~tick_d, a combinational pulse lasting one clk cycle.
  - tick_d resets to 1, so a tick_clk that is already high at reset release does not produce a tick.
- Key input:
  - key passes through a 2-flop synchronizer, giving key_s.
  - Priority encoder: enc_valid = |key_s, and enc = the lowest set index of key_s.
- Tick rule: all FSM, debounce and tone state changes only on clk edges where tick = 1. The only exceptions are reset and the rule that forces piezo to 0 (below).
- FSM states are IDLE, DEBOUNCE and PLAY.
  - IDLE: on tick, if enc_valid, go to DEBOUNCE with cand = enc and db_cnt = 1. If DEBOUNCE = 1, go straight to PLAY instead.
  - DEBOUNCE: on tick, decide in this order:
    - !enc_valid: go to IDLE.
    - enc ≠ cand: set cand = enc and db_cnt = 1.
    - db_cnt + 1 = DEBOUNCE: go to PLAY with note_idx = cand, tone_cnt = 0, piezo = 0.
    - Otherwise: db_cnt increments.
  - PLAY: on tick, decide in this order:
    - !enc_valid: go to IDLE.
    - enc ≠ note_idx: go to DEBOUNCE with cand = enc and db_cnt = 1.
    - Otherwise, when tone_cnt = HP[note_idx] − 1: set tone_cnt = 0 and toggle piezo.
    - Otherwise: tone_cnt increments.
- Leaving PLAY, for either release or a key change, clears note_valid and piezo on that same clk edge. There is no release debounce.
- Half-period table HP, in ticks, for index 0–7: 1911, 1703, 1517, 1432, 1276, 1136, 1012, 956. These are C4 D4 E4 F4 G4 A4 B4 C5 at a 1 MHz tick.
- Outputs:
  - note_valid = 1 exactly while in PLAY.
  - piezo = 0 whenever not in PLAY.
  - note_idx holds its last value outside PLAY.
- Arithmetic:
  - tone_cnt is an unsigned CNT_W-bit value that never exceeds HP − 1, so it never wraps.
  - db_cnt is 4 bits, saturating at DEBOUNCE.

## Timing
- Reset values: piezo 0, note_idx 0, note_valid 0, state IDLE, tick_d 1, synchronizer flops 0, cand 0, db_cnt 0, tone_cnt 0.
- Reset asserted mid-play forces every output to its reset value immediately, without waiting for a clock.
- Key-to-sample latency: 2 clk for the synchronizer, plus the wait until the next tick.
- Press-to-note_valid latency: DEBOUNCE ticks counted from the first tick that sees the key. note_valid rises on the clk edge of that DEBOUNCE-th tick.
- First piezo rise: HP[note_idx] ticks after PLAY entry. Tone period = 2·HP ticks.
- Tick period follows the upstream divider: 10 clk in /10 mode, 4 clk in /4 mode. A mode change takes effect on the next tick_clk rising edge. The pitch scales with it and no state is reset.
- Simultaneous events on one tick: release or key change takes priority over a piezo toggle.
- A key change during DEBOUNCE restarts the count at 1.

## Test plan
- Reset: hold rst = 1 with tick_clk = 1 and key = 8'h04. Required:
  - piezo, note_valid and note_idx are 0 throughout.
  - After releasing rst with tick_clk still 1, no tick is counted until tick_clk falls and rises again.
- Single key: drive tick_clk as a /10 wave and hold key = 8'h04. Required:
  - note_valid rises on the 4th tick after the sync delay.
  - note_idx = 2.
  - piezo first rises 1517 ticks (15170 clk) later and then toggles every 15170 clk.
- Bounce: set key = 8'h04 for 2 ticks, 8'h00 for 1 tick, then 8'h04 again. Required: IDLE is re-entered, and note_valid rises only after 4 further consecutive ticks.
- Priority and change: set key = 8'h22. Required:
  - After debounce, note_idx = 1 and the half-period is 1703 ticks.
  - When key is switched to 8'h20, on the next tick note_valid = 0 and piezo = 0.
  - 4 ticks later, note_idx = 5 with a half-period of 1136.
- Release and reset mid-play:
  - While in PLAY, set key = 0. Required: note_valid and piezo clear on the next tick.
  - In a separate run, assert rst asynchronously between clk edges while in PLAY. Required: piezo = 0 before the next clk edge.
- Rate switch: while playing index 7, change the divider from /10 to /4. Required: the piezo half-period changes from 9560 clk to 3824 clk, and note_valid stays 1.
